// File: rtl/burst_sig_gen.sv
// burst_sig_gen
//   Burst stimulus generator and output monitor for the I/Q weighting datapath.
//   A run sends NUM_BURST bursts of BURST_LEN accepted samples. Bursts are
//   separated by GAP_LEN idle cycles, and the run ends with a TAIL_LEN drain
//   and a one-cycle done pulse. The sample source is an LFSR, a ramp or a
//   constant, and the input handshake is valid/ready.
//   The monitor counts DUT output samples and folds them into a 16-bit
//   rotating signature.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          run control (abort wins over everything)
//   mode[1:0]             0 LFSR, 1 ramp, 2 constant, 3 LFSR
//   const_i/const_q       constant-mode sample data
//   in_ready              DUT accepts the presented sample
//   out_data_i/q, out_en  DUT output samples fed to the monitor
//   out_done              DUT end-of-output, retimed onto finish
//   in_data_i/q, in_w_i/q registered sample presented to the DUT
//   in_en                 sample valid
//   busy                  high while bursting, in a gap or draining
//   done                  one-cycle end-of-run pulse
//   finish                out_done delayed by two clocks (level)
//   out_count, out_sig    monitor sample count (saturating) and signature
module burst_sig_gen #(
  parameter int unsigned DW        = 12,
  parameter int unsigned WW        = 4,
  parameter int unsigned OW        = 9,
  parameter int unsigned BURST_LEN = 12,
  parameter int unsigned GAP_LEN   = 3,
  parameter int unsigned NUM_BURST = 10,
  parameter int unsigned TAIL_LEN  = 50,
  parameter logic [31:0] LFSR_SEED = 32'hACE11234
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] const_i,
  input  logic [DW-1:0] const_q,
  input  logic          in_ready,
  input  logic [OW-1:0] out_data_i,
  input  logic [OW-1:0] out_data_q,
  input  logic          out_en,
  input  logic          out_done,
  output logic [DW-1:0] in_data_i,
  output logic [DW-1:0] in_data_q,
  output logic [WW-1:0] in_w_i,
  output logic [WW-1:0] in_w_q,
  output logic          in_en,
  output logic          busy,
  output logic          done,
  output logic          finish,
  output logic [15:0]   out_count,
  output logic [15:0]   out_sig
);

  localparam int unsigned PW   = 2*DW + 2*WW;
  localparam int unsigned TMAX = (GAP_LEN > TAIL_LEN) ? GAP_LEN : TAIL_LEN;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam int unsigned SW   = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
  localparam int unsigned BW   = (NUM_BURST < 2) ? 1 : $clog2(NUM_BURST);
  localparam logic [31:0] TAPS = 32'h80200003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_GAP,
    S_TAIL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] sample_q, sample_d;   // {w_q, w_i, q, i}
  logic          in_en_q, in_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] idx_q, idx_d;         // ramp index of the next sample to load
  logic [SW-1:0] samp_q, samp_d;       // accepted samples in the current burst
  logic [BW-1:0] burst_q, burst_d;     // current burst number, from 0
  logic [TW-1:0] timer_q, timer_d;     // gap / tail countdown
  logic [15:0]   out_count_q, out_count_d;
  logic [15:0]   out_sig_q, out_sig_d;
  logic          fin1_q, fin1_d;
  logic          fin2_q, fin2_d;
  logic          accept;
  logic          mon_clear;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Builds one sample. The LFSR field layout is {w_q, w_i, q, i}, so the
  // low PW bits of the register are used directly.
  function automatic logic [PW-1:0] make_sample(
    input logic [1:0]    m,
    input logic [PW-1:0] l,
    input logic [DW-1:0] idx,
    input logic [DW-1:0] ci,
    input logic [DW-1:0] cq
  );
    logic [PW-1:0] s;
    s = '0;
    case (m)
      2'd1:    s = {idx[WW-1:0], idx[WW-1:0], ~idx, idx};
      2'd2:    s = {{(2*WW){1'b0}}, cq, ci};
      default: s = l;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    in_en_d     = in_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    samp_d      = samp_q;
    burst_d     = burst_q;
    timer_d     = timer_q;
    out_count_d = out_count_q;
    out_sig_d   = out_sig_q;
    fin1_d      = out_done;
    fin2_d      = fin1_q;
    mon_clear   = 1'b0;
    accept      = in_en_q & in_ready;

    if (abort) begin
      state_d = S_IDLE;
      in_en_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_BURST;
            in_en_d   = 1'b1;
            busy_d    = 1'b1;
            idx_d     = '0;
            samp_d    = '0;
            burst_d   = '0;
            mon_clear = 1'b1;
            sample_d  = make_sample(mode, lfsr_q[PW-1:0], '0, const_i, const_q);
          end
        end
        S_BURST: begin
          if (accept) begin
            lfsr_d = lfsr_step(lfsr_q);
            idx_d  = idx_q + DW'(1);
            if (samp_q == SW'(BURST_LEN - 1)) begin
              samp_d = '0;
              if (burst_q == BW'(NUM_BURST - 1)) begin
                state_d = S_TAIL;
                in_en_d = 1'b0;
                timer_d = TW'(TAIL_LEN - 1);
              end else begin
                burst_d = burst_q + BW'(1);
                if (GAP_LEN == 0) begin
                  sample_d = make_sample(mode, lfsr_d[PW-1:0], idx_d, const_i, const_q);
                end else begin
                  state_d = S_GAP;
                  in_en_d = 1'b0;
                  timer_d = TW'(GAP_LEN - 1);
                end
              end
            end else begin
              samp_d   = samp_q + SW'(1);
              sample_d = make_sample(mode, lfsr_d[PW-1:0], idx_d, const_i, const_q);
            end
          end
        end
        S_GAP: begin
          if (timer_q == '0) begin
            // LFSR and index already advanced on the last acceptance.
            state_d  = S_BURST;
            in_en_d  = 1'b1;
            sample_d = make_sample(mode, lfsr_q[PW-1:0], idx_q, const_i, const_q);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_TAIL: begin
          if (timer_q == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          in_en_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end

    // A start clears the monitor and drops any out_en seen in that cycle.
    if (mon_clear) begin
      out_count_d = '0;
      out_sig_d   = '0;
    end else if (out_en) begin
      if (out_count_q != 16'hFFFF) out_count_d = out_count_q + 16'd1;
      out_sig_d = {out_sig_q[14:0], out_sig_q[15]} ^ 16'(out_data_i)
                  ^ (16'(out_data_q) << (16 - OW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      in_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= '0;
      samp_q      <= '0;
      burst_q     <= '0;
      timer_q     <= '0;
      out_count_q <= '0;
      out_sig_q   <= '0;
      fin1_q      <= 1'b0;
      fin2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      in_en_q     <= in_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      samp_q      <= samp_d;
      burst_q     <= burst_d;
      timer_q     <= timer_d;
      out_count_q <= out_count_d;
      out_sig_q   <= out_sig_d;
      fin1_q      <= fin1_d;
      fin2_q      <= fin2_d;
    end
  end

  assign in_data_i = sample_q[DW-1:0];
  assign in_data_q = sample_q[2*DW-1:DW];
  assign in_w_i    = sample_q[2*DW+WW-1:2*DW];
  assign in_w_q    = sample_q[2*DW+2*WW-1:2*DW+WW];
  assign in_en     = in_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign finish    = fin2_q;
  assign out_count = out_count_q;
  assign out_sig   = out_sig_q;

endmodule
